// File: rtl/fc3_classify.sv
// LeNet output layer: streams N_IN F7 activations against N_OUT weight lanes,
// adds shifted per-class biases, then picks the highest score with a sequential argmax.
module fc3_classify #(
  parameter int N_IN    = 84,
  parameter int N_OUT   = 10,
  parameter int DW      = 16,
  parameter int WW      = 8,
  parameter int ACC_W   = 32,
  parameter int B_SHIFT = 8,
  parameter int RD_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [6:0]            f7_raddr,
  input  logic [DW-1:0]         f7_rdata,
  output logic [6:0]            w_raddr,
  input  logic [N_OUT*WW-1:0]   w_rdata,
  input  logic [N_OUT*16-1:0]   bias,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            class_out,
  output logic [ACC_W-1:0]      max_score
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, BIAS, ARGMAX, DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [6:0]                addr_q, addr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [RD_LAT-1:0]         vld_q;
  logic signed [ACC_W-1:0]   acc_q [N_OUT];
  logic signed [ACC_W-1:0]   acc_d [N_OUT];
  logic signed [ACC_W-1:0]   best_q, best_d;
  logic [3:0]                idx_q, idx_d;
  logic [3:0]                class_q, class_d;
  logic [ACC_W-1:0]          score_q, score_d;

  logic signed [DW-1:0]      f7_s;
  logic signed [WW-1:0]      w_s;
  logic signed [DW+WW-1:0]   prod;
  logic signed [15:0]        b_s;

  assign f7_s = signed'(f7_rdata);

  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    cnt_d   = '0;
    best_d  = best_q;
    idx_d   = idx_q;
    class_d = class_q;
    score_d = score_q;
    w_s     = '0;
    prod    = '0;
    b_s     = '0;
    for (int unsigned j = 0; j < N_OUT; j++) acc_d[j] = acc_q[j];

    // The tail of the valid chain marks the cycle a fetched word arrives.
    if (vld_q[RD_LAT-1]) begin
      for (int unsigned j = 0; j < N_OUT; j++) begin
        w_s      = signed'(w_rdata[j*WW +: WW]);
        prod     = f7_s * w_s;
        acc_d[j] = acc_q[j] + ACC_W'(prod);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          for (int unsigned j = 0; j < N_OUT; j++) acc_d[j] = '0;
        end
      end
      FETCH: begin
        if (addr_q == 7'(N_IN-1)) state_d = DRAIN;
        else                      addr_d  = addr_q + 7'd1;
      end
      DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(RD_LAT-1)) begin
          state_d = BIAS;
          cnt_d   = '0;
        end
      end
      BIAS: begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
          b_s      = signed'(bias[j*16 +: 16]);
          acc_d[j] = acc_q[j] + (ACC_W'(b_s) <<< B_SHIFT);
        end
        state_d = ARGMAX;
      end
      ARGMAX: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == '0) begin
          best_d = acc_q[0];
          idx_d  = '0;
        end else if (acc_q[cnt_q] > best_q) begin
          best_d = acc_q[cnt_q];
          idx_d  = cnt_q;
        end
        // Results are latched on the final compare so they are valid during DONE.
        if (cnt_q == 4'(N_OUT-1)) begin
          state_d = DONE;
          cnt_d   = '0;
          class_d = idx_d;
          score_d = best_d;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= '0;
      best_q  <= '0;
      idx_q   <= '0;
      class_q <= '0;
      score_q <= '0;
      for (int unsigned j = 0; j < N_OUT; j++) acc_q[j] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      vld_q   <= RD_LAT'({vld_q, state_q == FETCH});
      best_q  <= best_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      score_q <= score_d;
      for (int unsigned j = 0; j < N_OUT; j++) acc_q[j] <= acc_d[j];
    end
  end

  assign f7_raddr  = addr_q;
  assign w_raddr   = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign class_out = class_q;
  assign max_score = score_q;

endmodule

// File: tb/tb_fc3_classify.sv
// Bench for fc3_classify: directed corner jobs plus random jobs, each checked
// against a plain-arithmetic dot-product/argmax reference.
module tb_fc3_classify;
  localparam int N_IN  = 84;
  localparam int N_OUT = 10;
  localparam int LAT   = 98;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [6:0]   f7_raddr, w_raddr;
  logic [15:0]  f7_rdata;
  logic [79:0]  w_rdata;
  logic [159:0] biasv;
  logic         busy, done;
  logic [3:0]   class_out;
  logic [31:0]  max_score;

  logic signed [15:0] f7m [N_IN];
  logic [79:0]        wm  [N_IN];
  logic [6:0]         f7_a1, w_a1;

  int n_tests = 0;
  int n_fail  = 0;

  fc3_classify #(.N_IN(84), .N_OUT(10), .DW(16), .WW(8), .ACC_W(32), .B_SHIFT(8), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .f7_raddr(f7_raddr), .f7_rdata(f7_rdata),
    .w_raddr(w_raddr), .w_rdata(w_rdata), .bias(biasv),
    .busy(busy), .done(done), .class_out(class_out), .max_score(max_score)
  );

  always #5 clk = ~clk;

  // Two-cycle synchronous read memories.
  always @(posedge clk) begin
    f7_a1    <= f7_raddr;
    w_a1     <= w_raddr;
    f7_rdata <= (f7_a1 < N_IN) ? f7m[f7_a1] : 16'h0;
    w_rdata  <= (w_a1 < N_IN) ? wm[w_a1] : 80'h0;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(output int cls, output longint score);
    longint s [N_OUT];
    logic signed [7:0]  w;
    logic signed [15:0] b;
    for (int j = 0; j < N_OUT; j++) begin
      s[j] = 0;
      for (int k = 0; k < N_IN; k++) begin
        w = wm[k][j*8 +: 8];
        s[j] += longint'(f7m[k]) * longint'(w);
      end
      b = biasv[j*16 +: 16];
      s[j] += longint'(b) * 256;
    end
    cls = 0; score = s[0];
    for (int j = 1; j < N_OUT; j++)
      if (s[j] > score) begin cls = j; score = s[j]; end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < N_IN; k++) begin f7m[k] = '0; wm[k] = '0; end
    biasv = '0;
  endtask

  // Starts a job, checks latency, address stream, busy and results against the model.
  // When extra_starts is set, extra start pulses are driven at cycles 10 and 98.
  task automatic run_job(input string tag, input bit extra_starts);
    int     cyc, addr_err, exp_cls;
    longint exp_score;
    model(exp_cls, exp_score);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1; addr_err = 0;
    check({tag, "_busy"}, busy, 1);
    while (!done && cyc < 300) begin
      if (cyc <= N_IN) begin
        if (f7_raddr != 7'(cyc-1) || w_raddr != 7'(cyc-1)) addr_err++;
      end else if (f7_raddr != 0 || w_raddr != 0) addr_err++;
      if (extra_starts && cyc == 10) start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_addr_seq"}, addr_err, 0);
    check({tag, "_class"}, class_out, exp_cls);
    check({tag, "_score"}, longint'($signed(max_score)), exp_score);
    if (extra_starts) start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_done_width"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, class_out, exp_cls);
  endtask

  initial begin
    int errs;
    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_class", class_out, 0);
    check("reset_score", max_score, 0);
    check("reset_addr", f7_raddr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero activations, rising biases
    for (int k = 0; k < N_IN; k++) wm[k] = {$urandom, $urandom, $urandom};
    for (int j = 0; j < N_OUT; j++) biasv[j*16 +: 16] = 16'(j*16);
    run_job("s1", 0);
    check("s1_score_abs", longint'($signed(max_score)), 36864);

    // 2: single active input and weight
    clear_mem();
    f7m[5] = 16'sd256; wm[5][3*8 +: 8] = 8'd2;
    run_job("s2", 0);
    check("s2_class_abs", class_out, 3);

    // 3: tie keeps lowest index
    clear_mem();
    biasv[2*16 +: 16] = 16'd100; biasv[7*16 +: 16] = 16'd100;
    run_job("s3", 0);
    check("s3_class_abs", class_out, 2);

    // 4: all-negative scores
    clear_mem();
    for (int j = 0; j < N_OUT; j++) biasv[j*16 +: 16] = 16'(-(j+1));
    run_job("s4", 0);
    check("s4_score_abs", longint'($signed(max_score)), -256);

    // 5: starts while busy and during DONE are ignored
    run_job("s5", 1);
    errs = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (done || busy || f7_raddr != 0) errs++;
    end
    check("s5_no_rerun", errs, 0);

    // 6: reset mid-fetch discards the job
    clear_mem();
    f7m[5] = 16'sd256; wm[5][3*8 +: 8] = 8'd2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    check("s6_addr_k40", f7_raddr, 40);
    rst_n = 1'b0;
    #1;
    check("s6_busy_rst", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    errs = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      if (done || busy) errs++;
    end
    check("s6_no_done", errs, 0);
    check("s6_class_clr", class_out, 0);
    run_job("s6", 0);
    check("s6_score_abs", longint'($signed(max_score)), 512);

    // random jobs
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < N_IN; k++) begin
        f7m[k] = 16'($urandom);
        wm[k]  = {$urandom, $urandom, $urandom};
      end
      for (int j = 0; j < N_OUT; j++) biasv[j*16 +: 16] = 16'($urandom);
      // occasionally force a tie on the top lane pair by copying a column
      if (t == 5) begin
        for (int k = 0; k < N_IN; k++) wm[k][8*8 +: 8] = wm[k][4*8 +: 8];
        biasv[8*16 +: 16] = biasv[4*16 +: 16];
      end
      run_job($sformatf("rnd%0d", t), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
